// File: rtl/tvip_reset_gen_if.sv
// Request/acknowledge and status bundle between the test sequence and the reset generator.
interface tvip_reset_gen_if;
  logic       reset_request;
  logic [7:0] reset_cycles;
  logic       reset_ack;
  logic       reset_n_out;
  logic       busy;
  logic [7:0] reset_count;

  modport master (
    output reset_request, reset_cycles,
    input  reset_ack, reset_n_out, busy, reset_count
  );

  modport slave (
    input  reset_request, reset_cycles,
    output reset_ack, reset_n_out, busy, reset_count
  );
endinterface

// File: rtl/tvip_reset_gen.sv
// Clock-aligned reset generator: synchronizes raw rst_n, stretches the output reset,
// and services run-time reset requests with an ack and a saturating completion count.
module tvip_reset_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tvip_reset_gen_if.slave  bus
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SYNC, HOLD, RUN} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       len_q;
  logic                   from_req_q;
  logic                   reset_n_q;
  logic                   busy_q;
  logic                   ack_q;
  logic [CNT_W-1:0]       count_q;

  assign sync_next = {sync_q[SYNC_STAGES-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      sync_q     <= '0;
      cnt_q      <= '0;
      len_q      <= DEF_LEN;
      from_req_q <= 1'b0;
      reset_n_q  <= 1'b0;
      busy_q     <= 1'b1;
      ack_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        SYNC: begin
          sync_q <= sync_next;
          if (sync_next[SYNC_STAGES-1]) begin
            state_q    <= HOLD;
            len_q      <= DEF_LEN;
            cnt_q      <= '0;
            from_req_q <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_q   <= RUN;
            reset_n_q <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            // Only request-initiated holds are counted; power-on holds are not.
            if (from_req_q && (count_q != CNT_MAX)) begin
              count_q <= count_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (bus.reset_request) begin
            state_q    <= HOLD;
            len_q      <= (bus.reset_cycles == '0) ? DEF_LEN : bus.reset_cycles;
            cnt_q      <= '0;
            from_req_q <= 1'b1;
            reset_n_q  <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b1;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign bus.reset_ack   = ack_q;
  assign bus.reset_n_out = reset_n_q;
  assign bus.busy        = busy_q;
  assign bus.reset_count = count_q;

endmodule
